// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide: radix-2 shift-add multiply and restoring divide, one bit per clock.
// Optional macro MDU_ZERO_SHORTCUT_EN: zero-operand multiplies/divides finish at the first edge.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             mult_done,
  output logic             div_done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 op_div_q, op_div_d;
  logic                 rsign_q, rsign_d, dsign_q, dsign_d;
  logic                 dbz_q, dbz_d, zero_q, zero_d;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic s);
    return s ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_p(input logic [2*WIDTH-1:0] v, input logic s);
    return s ? -v : v;
  endfunction

  // Restoring step: accumulator holds {remainder, dividend/quotient shift register}.
  always_comb begin
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mcand_q[WIDTH-1:0]};
    div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, mcand_q[WIDTH-1:0]}) : div_shift[WIDTH-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op_div_d = op_div_q;
    rsign_d  = rsign_q;
    dsign_d  = dsign_q;
    dbz_d    = dbz_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (mult_start || div_start) begin
          cnt_d    = '0;
          rsign_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1];
          dsign_d  = a_in[WIDTH-1];
          mcand_d  = {{WIDTH{1'b0}}, mag(mult_start ? a_in : b_in)};
          op_div_d = !mult_start;
          if (mult_start) begin
            state_d  = MUL_RUN;
            acc_d    = '0;
            mplier_d = mag(b_in);
            dbz_d    = 1'b0;
`ifdef MDU_ZERO_SHORTCUT_EN
            zero_d   = (a_in == '0) || (b_in == '0);
`else
            zero_d   = 1'b0;
`endif
          end else begin
            state_d  = DIV_RUN;
            acc_d    = {{WIDTH{1'b0}}, mag(a_in)};
            mplier_d = '0;
            dbz_d    = (b_in == '0);
`ifdef MDU_ZERO_SHORTCUT_EN
            zero_d   = (a_in == '0) && (b_in != '0);
`else
            zero_d   = 1'b0;
`endif
          end
        end
      end
      MUL_RUN: begin
        if (zero_q) begin
          hi_d    = '0;
          lo_d    = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          {hi_d, lo_d} = neg_p(acc_q, rsign_q);
          state_d      = DONE;
        end else begin
          acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      DIV_RUN: begin
        if (dbz_q) begin
          state_d = DONE;
        end else if (zero_q) begin
          hi_d    = '0;
          lo_d    = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          lo_d    = neg_w(acc_q[WIDTH-1:0], rsign_q);
          hi_d    = neg_w(acc_q[2*WIDTH-1:WIDTH], dsign_q);
          state_d = DONE;
        end else begin
          acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_div_q <= 1'b0;
      rsign_q  <= 1'b0;
      dsign_q  <= 1'b0;
      dbz_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      op_div_q <= op_div_d;
      rsign_q  <= rsign_d;
      dsign_q  <= dsign_d;
      dbz_q    <= dbz_d;
      zero_q   <= zero_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign mult_done   = (state_q == DONE) && !op_div_q;
  assign div_done    = (state_q == DONE) && op_div_q;
  assign div_by_zero = div_done && dbz_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signed results, divide-by-zero, start collisions and reset abort.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mult_start = 1'b0;
  logic        div_start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        mult_done, div_done, busy, div_by_zero;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_fail   = 0;

  int   lat, n_md, n_dd, n_any;
  logic dbz_seen, busy_ok;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
    .a_in(a_in), .b_in(b_in), .mult_done(mult_done), .div_done(div_done),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one start, then watch 41 cycles (cycle k = the one following edge E_k).
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output int lt, output int nm, output int nd,
                        output logic dz, output logic bok);
    @(negedge clk);
    mult_start = m; div_start = d; a_in = a; b_in = b;
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0; a_in = 32'hDEADBEEF; b_in = 32'h0BADF00D;
    lt = -1; nm = 0; nd = 0; dz = 1'b0; bok = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) @(negedge clk);
      if (k == inj) mult_start = 1'b1;
      if (k == inj + 1) mult_start = 1'b0;
      if (mult_done) nm++;
      if (div_done) nd++;
      if (div_by_zero) dz = 1'b1;
      if ((mult_done || div_done) && lt < 0) lt = k;
      if (busy !== ((lt < 0) || (k == lt))) bok = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_lo", lo_out, 32'h0);
    chk("rst_flags", {28'h0, mult_done, div_done, busy, div_by_zero}, 32'h0);
    reset = 1'b1;

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, -5, lat, n_md, n_dd, dbz_seen, busy_ok);
    chk("m7x-3_lat", lat, 32'd33);
    chk("m7x-3_pulses", {n_md[15:0], n_dd[15:0]}, {16'd1, 16'd0});
    chk("m7x-3_hi", hi_out, 32'hFFFFFFFF);
    chk("m7x-3_lo", lo_out, 32'hFFFFFFEB);
    chk("m7x-3_busy", busy_ok, 1'b1);

    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, -5, lat, n_md, n_dd, dbz_seen, busy_ok);
    chk("d-7/2_lat", lat, 32'd33);
    chk("d-7/2_pulses", {n_md[15:0], n_dd[15:0]}, {16'd0, 16'd1});
    chk("d-7/2_lo", lo_out, 32'hFFFFFFFD);
    chk("d-7/2_hi", hi_out, 32'hFFFFFFFF);
    chk("d-7/2_dbz", dbz_seen, 1'b0);

    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, -5, lat, n_md, n_dd, dbz_seen, busy_ok);
    chk("dovf_lo", lo_out, 32'h80000000);
    chk("dovf_hi", hi_out, 32'h0);

    run_op(1'b0, 1'b1, 32'd100, 32'd7, -5, lat, n_md, n_dd, dbz_seen, busy_ok);
    chk("d100/7_lo", lo_out, 32'd14);
    chk("d100/7_hi", hi_out, 32'd2);
    chk("d100/7_busy", busy_ok, 1'b1);

    run_op(1'b0, 1'b1, 32'd5, 32'd2, -5, lat, n_md, n_dd, dbz_seen, busy_ok);
    chk("d5/2_lo", lo_out, 32'd2);
    chk("d5/2_hi", hi_out, 32'd1);

    run_op(1'b0, 1'b1, 32'd123, 32'd0, -5, lat, n_md, n_dd, dbz_seen, busy_ok);
    chk("dz_lat", lat, 32'd1);
    chk("dz_pulses", {n_md[15:0], n_dd[15:0]}, {16'd0, 16'd1});
    chk("dz_flag", dbz_seen, 1'b1);
    chk("dz_hi_keep", hi_out, 32'h1);
    chk("dz_lo_keep", lo_out, 32'h2);
    chk("dz_busy", busy_ok, 1'b1);

    run_op(1'b1, 1'b1, 32'd3, 32'd5, 10, lat, n_md, n_dd, dbz_seen, busy_ok);
    chk("both_lat", lat, 32'd33);
    chk("both_pulses", {n_md[15:0], n_dd[15:0]}, {16'd1, 16'd0});
    chk("both_lo", lo_out, 32'd15);
    chk("both_hi", hi_out, 32'd0);

    @(negedge clk);
    mult_start = 1'b1; a_in = 32'd9; b_in = 32'd9;
    @(negedge clk);
    mult_start = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_lo", lo_out, 32'h0);
    chk("abort_flags", {28'h0, mult_done, div_done, busy, div_by_zero}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    n_any = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mult_done || div_done || busy) n_any++;
    end
    chk("abort_no_done", n_any, 32'd0);

    run_op(1'b1, 1'b0, 32'h0000FFFF, 32'h0000FFFF, -5, lat, n_md, n_dd, dbz_seen, busy_ok);
    chk("mffff_lat", lat, 32'd33);
    chk("mffff_hi", hi_out, 32'h0);
    chk("mffff_lo", lo_out, 32'hFFFE0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
